// File: rtl/cl_axi_lite_pkg.sv
// Shared types for the CL AXI-Lite init master: response codes, FSM states,
// and the error counter width.
package cl_axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP,
        DONE
    } init_state_e;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/axi_lite_if.sv
// 32-bit AXI-Lite bundle with master and slave views.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/cl_axi_lite_init_master.sv
// AXI-Lite master that plays a fixed register-write table after reset or on
// start, then parks the bus in the tie-down state (valids low, readies high).
module cl_axi_lite_init_master
    import cl_axi_lite_pkg::*;
#(
    parameter int          NUM_WRITES                  = 4,
    parameter logic [31:0] INIT_ADDR [NUM_WRITES]      = '{default: 32'h0},
    parameter logic [31:0] INIT_DATA [NUM_WRITES]      = '{default: 32'h0},
    parameter logic [3:0]  INIT_STRB [NUM_WRITES]      = '{default: 4'hF},
    parameter bit          AUTO_START                  = 1'b1,
    parameter int          TIMEOUT_CYCLES              = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    axi_lite_if.master           axi_lite_master_bus,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 timeout
);

    localparam int IDX_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WRITES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    init_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                 aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
    logic [31:0]          awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic                 auto_q, auto_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic                 aw_hs, w_hs, launch, load;
    logic [1:0]           err_inc;
    logic [ERR_CNT_W:0]   err_sum;
    logic                 unused_rd;

    assign aw_hs = awvalid_q & axi_lite_master_bus.awready;
    assign w_hs  = wvalid_q & axi_lite_master_bus.wready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_ok_d     = aw_ok_q;
        w_ok_d      = w_ok_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        auto_d      = auto_q;
        tmo_cnt_d   = tmo_cnt_q;
        launch      = 1'b0;
        load        = 1'b0;
        err_inc     = 2'd0;

        // Read data and any B beat outside the RESP wait are protocol noise.
        if (axi_lite_master_bus.rvalid) err_inc = err_inc + 2'd1;
        if (axi_lite_master_bus.bvalid && state_q != RESP) err_inc = err_inc + 2'd1;

        if (state_q == ADDR_DATA || state_q == RESP) begin
            if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TMO_MAX - 1'b1) timeout_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start || auto_q) launch = 1'b1;
            end
            ADDR_DATA: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_ok_d   = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_ok_d   = 1'b1;
                end
                if ((aw_ok_q || aw_hs) && (w_ok_q || w_hs)) state_d = RESP;
            end
            RESP: begin
                if (axi_lite_master_bus.bvalid) begin
                    if (axi_lite_master_bus.bresp != OKAY) err_inc = err_inc + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        load    = 1'b1;
                        state_d = ADDR_DATA;
                    end
                end
            end
            DONE: begin
                if (start) launch = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            idx_d     = '0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            auto_d    = 1'b0;
            load      = 1'b1;
            state_d   = ADDR_DATA;
        end

        if (load) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_ok_d   = 1'b0;
            w_ok_d    = 1'b0;
            tmo_cnt_d = '0;
            awaddr_d  = INIT_ADDR[idx_d];
            wdata_d   = INIT_DATA[idx_d];
            wstrb_d   = INIT_STRB[idx_d];
        end

        err_sum     = {1'b0, err_count_q} + (ERR_CNT_W + 1)'(err_inc);
        err_count_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_ok_q     <= 1'b0;
            w_ok_q      <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            auto_q      <= AUTO_START;
            tmo_cnt_q   <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_ok_q     <= aw_ok_d;
            w_ok_q      <= w_ok_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            auto_q      <= auto_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign axi_lite_master_bus.awaddr  = awaddr_q;
    assign axi_lite_master_bus.awvalid = awvalid_q;
    assign axi_lite_master_bus.wdata   = wdata_q;
    assign axi_lite_master_bus.wstrb   = wstrb_q;
    assign axi_lite_master_bus.wvalid  = wvalid_q;
    assign axi_lite_master_bus.bready  = 1'b1;
    assign axi_lite_master_bus.araddr  = 32'h0;
    assign axi_lite_master_bus.arvalid = 1'b0;
    assign axi_lite_master_bus.rready  = 1'b1;

    assign unused_rd = ^{axi_lite_master_bus.arready, axi_lite_master_bus.rdata,
                         axi_lite_master_bus.rresp};

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign err_count = err_count_q;

endmodule
